// File: rtl/fpu_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pa_fpu : FPU operation codes and the two-requester arbiter state encoding.
// Revision: 1.0
// ----------------------------------------------------------------------------
package pa_fpu;

  typedef enum logic [3:0] {
    FPU_ADD  = 4'h0,
    FPU_SUB  = 4'h1,
    FPU_MUL  = 4'h2,
    FPU_DIV  = 4'h3,
    FPU_SQRT = 4'h4,
    FPU_MIN  = 4'h5,
    FPU_MAX  = 4'h6,
    FPU_CMP  = 4'h7,
    FPU_I2F  = 4'h8,
    FPU_F2I  = 4'h9
  } e_fpu_operation;

  // Codes above this are unassigned and answered with an error response.
  localparam logic [3:0] FPU_OP_LAST = 4'h9;

  typedef enum logic [1:0] {
    arb_idle_st  = 2'd0,
    arb_issue_st = 2'd1,
    arb_wait_st  = 2'd2,
    arb_resp_st  = 2'd3
  } e_arb_state;

  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= FPU_OP_LAST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_arbiter : round-robin sharing of one FPU core between two requesters.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fpu_arbiter
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  e_fpu_operation req_op [2],
  input  logic [31:0]    req_a  [2],
  input  logic [31:0]    req_b  [2],
  output logic [1:0]     rsp_valid,
  output logic [31:0]    rsp_result,
  output logic           rsp_err,
  output logic           fpu_start,
  output e_fpu_operation fpu_op,
  output logic [31:0]    fpu_a,
  output logic [31:0]    fpu_b,
  input  logic [31:0]    fpu_result,
  input  logic           fpu_done,
  output logic           busy,
  output logic           owner
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  e_arb_state     state;
  e_arb_state     state_nxt;
  logic           last_grant;
  logic           winner;
  logic           handshake;
  logic           owner_q;
  logic           err_q;
  e_fpu_operation op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic [31:0]    result_q;
  logic [15:0]    wait_cnt;
  logic           op_active;

  // On contention the requester that was not granted last wins.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= arb_idle_st;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    fpu_start = 1'b0;
    rsp_valid = 2'b00;
    case (state)
      arb_idle_st: begin
        // Gated by arst_n so ready stays low while reset is held.
        if ((|req_valid) && arst_n) begin
          req_ready[winner] = 1'b1;
          state_nxt = is_valid_op(req_op[winner]) ? arb_issue_st : arb_resp_st;
        end
      end
      arb_issue_st: begin
        fpu_start = 1'b1;
        state_nxt = arb_wait_st;
      end
      arb_wait_st: begin
        if (fpu_done || (wait_cnt == TIMEOUT_LIM)) state_nxt = arb_resp_st;
      end
      arb_resp_st: begin
        rsp_valid[owner_q] = 1'b1;
        state_nxt = arb_idle_st;
      end
      default: state_nxt = arb_idle_st;
    endcase
  end

  assign handshake = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      op_q       <= FPU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        arb_idle_st: begin
          if (handshake) begin
            last_grant <= winner;
            owner_q    <= winner;
            op_q       <= req_op[winner];
            a_q        <= req_a[winner];
            b_q        <= req_b[winner];
            result_q   <= '0;
            err_q      <= ~is_valid_op(req_op[winner]);
          end
        end
        arb_issue_st: wait_cnt <= 16'd1;
        arb_wait_st: begin
          // A completion in the timeout cycle still counts as success.
          if (fpu_done) begin
            result_q <= fpu_result;
            err_q    <= 1'b0;
          end else if (wait_cnt == TIMEOUT_LIM) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_active  = (state == arb_issue_st) || (state == arb_wait_st);
  assign fpu_op     = op_active ? op_q : FPU_ADD;
  assign fpu_a      = op_active ? a_q : 32'h0;
  assign fpu_b      = op_active ? b_q : 32'h0;
  assign rsp_result = (state == arb_resp_st) ? result_q : 32'h0;
  assign rsp_err    = (state == arb_resp_st) ? err_q : 1'b0;
  assign busy       = (state != arb_idle_st);
  assign owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpu_arbiter : vector table, directed corner sequences and random traffic.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fpu_arbiter;
  import pa_fpu::*;

  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  e_fpu_operation req_op [2];
  logic [31:0]    req_a  [2];
  logic [31:0]    req_b  [2];
  logic [1:0]     rsp_valid;
  logic [31:0]    rsp_result;
  logic           rsp_err;
  logic           fpu_start;
  e_fpu_operation fpu_op;
  logic [31:0]    fpu_a;
  logic [31:0]    fpu_b;
  logic [31:0]    fpu_result;
  logic           fpu_done;
  logic           busy;
  logic           owner;

  fpu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_done(fpu_done),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Fake FPU core: answers core_lat cycles after a start (0 = never answers).
  int          core_lat = 0;
  int          core_cnt = 0;
  logic [31:0] core_res = 0;
  logic [31:0] core_hold = 0;
  int          starts = 0;
  logic [3:0]  st_op = 0;
  logic [31:0] st_a = 0;
  logic [31:0] st_b = 0;
  logic        spur = 1'b0;

  initial begin
    fpu_done = 1'b0;
    fpu_result = 32'h0;
    forever begin
      @(negedge clk);
      fpu_done = 1'b0;
      fpu_result = 32'h0;
      if (!arst_n) core_cnt = 0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          fpu_done = 1'b1;
          fpu_result = core_hold;
        end
      end
      if (fpu_start) begin
        starts++;
        st_op = fpu_op;
        st_a = fpu_a;
        st_b = fpu_b;
        core_cnt = core_lat;
        core_hold = core_res;
      end
      if (spur) begin
        fpu_done = 1'b1;
        fpu_result = 32'hDEADBEEF;
        spur = 1'b0;
      end
    end
  end

  // Reference outcome of one accepted request.
  function automatic void model(input logic [3:0] op, input int lat, input logic [31:0] res,
                                output logic [31:0] r, output logic e, output int l, output int s);
    if (op > 4'd9) begin
      r = 32'h0; e = 1'b1; l = 1; s = 0;
    end else if (lat >= 1 && lat <= TO) begin
      r = res; e = 1'b0; l = 2 + lat; s = 1;
    end else begin
      r = 32'h0; e = 1'b1; l = 2 + TO; s = 1;
    end
  endfunction

  // Requests must already be driven; runs one grant through to its response.
  task automatic do_txn(input logic [1:0] exp_oh, input int lat, input logic [31:0] res,
                        input logic [31:0] exp_res, input logic exp_err, input int exp_lat,
                        input int exp_starts, input logic [3:0] exp_op,
                        input logic [31:0] exp_a, input logic [31:0] exp_b, input string tag);
    int cyc;
    int s0;
    int w;
    logic rdy_busy;
    core_lat = lat;
    core_res = res;
    #1;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    chk($sformatf("%s grant", tag), 128'(req_ready), 128'(exp_oh));
    w = req_ready[1] ? 1 : 0;
    s0 = starts;
    @(negedge clk);
    req_valid[w] = 1'b0;
    #1;
    cyc = 1;
    rdy_busy = 1'b0;
    while (rsp_valid == 2'b00 && cyc < 100) begin
      if (req_ready != 2'b00) rdy_busy = 1'b1;
      @(negedge clk); #1; cyc++;
    end
    chk($sformatf("%s rsp_valid", tag), 128'(rsp_valid), 128'(exp_oh));
    chk($sformatf("%s result/err", tag), {rsp_result, rsp_err}, {exp_res, exp_err});
    chk($sformatf("%s latency", tag), 128'(cyc), 128'(exp_lat));
    chk($sformatf("%s starts", tag), 128'(starts - s0), 128'(exp_starts));
    chk($sformatf("%s ready while busy", tag), 128'(rdy_busy), 128'(0));
    if (exp_starts == 1)
      chk($sformatf("%s fpu payload", tag), {st_op, st_a, st_b}, {exp_op, exp_a, exp_b});
    @(negedge clk); #1;
    chk($sformatf("%s pulse end", tag), {rsp_valid, busy}, 128'(0));
  endtask

  typedef struct {
    int          sel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic [1:0]  rv;
    logic [31:0] eres;
    logic        eerr;
    int          elat;
    int          est;
  } vec_t;

  vec_t vt [9];
  logic [1:0] rr_exp [3];

  initial begin
    int          cyc;
    logic        seen;
    logic [1:0]  pend;
    logic [3:0]  pop [2];
    logic [31:0] pa  [2];
    logic [31:0] pb  [2];
    int          ml;
    int          wn;
    int          lat;
    logic [31:0] res;
    logic [31:0] er;
    logic        ee;
    int          el;
    int          es;

    vt[0] = '{0, 4'h2, 32'h3F800000, 32'h40000000, 2, 32'h40000000, 2'b01, 32'h40000000, 1'b0, 4, 1};
    vt[1] = '{1, 4'hC, 32'h11111111, 32'h22222222, 1, 32'h00000005, 2'b10, 32'h0, 1'b1, 1, 0};
    vt[2] = '{0, 4'h0, 32'h00000001, 32'h00000002, 0, 32'h00000003, 2'b01, 32'h0, 1'b1, 6, 1};
    vt[3] = '{1, 4'h3, 32'hAAAA5555, 32'h0F0F0F0F, 4, 32'h12345678, 2'b10, 32'h12345678, 1'b0, 6, 1};
    vt[4] = '{0, 4'h1, 32'h80000001, 32'h7FFFFFFF, 1, 32'hCAFEF00D, 2'b01, 32'hCAFEF00D, 1'b0, 3, 1};
    vt[5] = '{1, 4'hA, 32'h00000010, 32'h00000020, 2, 32'h00000099, 2'b10, 32'h0, 1'b1, 1, 0};
    vt[6] = '{0, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000011, 2'b01, 32'h0, 1'b1, 1, 0};
    vt[7] = '{1, 4'h9, 32'h13579BDF, 32'h02468ACE, 3, 32'h0BADC0DE, 2'b10, 32'h0BADC0DE, 1'b0, 5, 1};
    vt[8] = '{0, 4'h6, 32'h00000042, 32'h00000024, 5, 32'h00000077, 2'b01, 32'h0, 1'b1, 6, 1};
    rr_exp[0] = 2'b01;
    rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01;

    // Reset with both requesters valid: everything must stay low.
    req_valid = 2'b11;
    req_op[0] = e_fpu_operation'(4'hB);
    req_op[1] = e_fpu_operation'(4'hB);
    req_a[0] = 32'h1; req_b[0] = 32'h2;
    req_a[1] = 32'h3; req_b[1] = 32'h4;
    @(negedge clk); @(negedge clk); #1;
    chk("reset outputs",
        {req_ready, rsp_valid, fpu_start, busy, owner, fpu_op, fpu_a, fpu_b, rsp_result, rsp_err},
        128'(0));

    // Round robin with both held valid.
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (req_ready == 2'b00 && cyc < 20) begin
        @(negedge clk); #1; cyc++;
      end
      chk($sformatf("rr grant %0d", k), 128'(req_ready), 128'(rr_exp[k]));
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    @(negedge clk); @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      req_valid[vt[i].sel] = 1'b1;
      req_op[vt[i].sel] = e_fpu_operation'(vt[i].op);
      req_a[vt[i].sel] = vt[i].a;
      req_b[vt[i].sel] = vt[i].b;
      do_txn(vt[i].rv, vt[i].lat, vt[i].res, vt[i].eres, vt[i].eerr, vt[i].elat,
             vt[i].est, vt[i].op, vt[i].a, vt[i].b, $sformatf("vec%0d", i));
    end

    // Spurious completion while idle.
    @(negedge clk);
    spur = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00 || busy) seen = 1'b1;
    end
    chk("spurious done ignored", 128'(seen), 128'(0));

    // Reset in the middle of a wait.
    @(negedge clk);
    req_valid = 2'b10;
    req_op[1] = FPU_MIN;
    req_a[1] = 32'h5555AAAA;
    req_b[1] = 32'h3C3C3C3C;
    core_lat = 0;
    #1;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); @(negedge clk); #1;
    chk("pre-reset busy/owner", {busy, owner}, 128'(2'b11));
    arst_n = 1'b0;
    #1;
    chk("reset mid-wait outputs",
        {req_ready, rsp_valid, fpu_start, busy, owner, fpu_op, fpu_a, fpu_b, rsp_result, rsp_err},
        128'(0));
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    chk("no response after reset abort", 128'(seen), 128'(0));

    // After reset requester 0 wins the first contested grant.
    req_valid = 2'b11;
    req_op[0] = FPU_ADD; req_a[0] = 32'h00000111; req_b[0] = 32'h00000222;
    req_op[1] = FPU_SUB; req_a[1] = 32'h00000333; req_b[1] = 32'h00000444;
    do_txn(2'b01, 1, 32'h00ABCDEF, 32'h00ABCDEF, 1'b0, 3, 1, 4'h0,
           32'h00000111, 32'h00000222, "post-reset r0");
    do_txn(2'b10, 2, 32'h00FEDCBA, 32'h00FEDCBA, 1'b0, 4, 1, 4'h1,
           32'h00000333, 32'h00000444, "post-reset r1");

    // Random traffic against the reference model.
    ml = 1;
    pend = 2'b00;
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          pend[r] = 1'b1;
          pop[r] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
          pa[r] = $urandom;
          pb[r] = $urandom;
        end
      end
      if (pend == 2'b00) begin
        wn = $urandom_range(0, 1);
        pend[wn] = 1'b1;
        pop[wn] = 4'($urandom_range(0, 15));
        pa[wn] = $urandom;
        pb[wn] = $urandom;
      end
      for (int r = 0; r < 2; r++) begin
        req_valid[r] = pend[r];
        req_op[r] = e_fpu_operation'(pop[r]);
        req_a[r] = pa[r];
        req_b[r] = pb[r];
      end
      wn = (pend == 2'b11) ? (1 - ml) : (pend[0] ? 0 : 1);
      lat = $urandom_range(0, 6);
      res = $urandom;
      model(pop[wn], lat, res, er, ee, el, es);
      do_txn(2'b01 << wn, lat, res, er, ee, el, es, pop[wn], pa[wn], pb[wn],
             $sformatf("rnd%0d", it));
      pend[wn] = 1'b0;
      ml = wn;
    end

    req_valid = 2'b00;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited for fpu_done before an error response (range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all flops rise-edge.
REQ-003 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit 0 = requester 0).
REQ-005 SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 SHALL have port req_op  input  2x4  per-requester operation, type e_fpu_operation.
REQ-007 SHALL have port req_a  input  2x32  per-requester operand A.
REQ-008 SHALL have port req_b  input  2x32  per-requester operand B.
REQ-009 SHALL have port rsp_valid  output  2  one-cycle response pulse to the owning requester.
REQ-010 SHALL have port rsp_result  output  32  result; meaningful only while rsp_valid is nonzero.
REQ-011 SHALL have port rsp_err  output  1  error flag qualified by rsp_valid.
REQ-012 SHALL have port fpu_start  output  1  one-cycle start pulse to the shared FPU core.
REQ-013 SHALL have port fpu_op  output  4  operation to FPU core (e_fpu_operation).
REQ-014 SHALL have ports fpu_a, fpu_b  output  32 each  operands to FPU core.
REQ-015 SHALL have port fpu_result  input  32  FPU core result, valid with fpu_done.
REQ-016 SHALL have port fpu_done  input  1  FPU core completion pulse.
REQ-017 SHALL have ports busy  output  1 (state != idle) and owner  output  1 (index of current requester).

Function
REQ-018 SHALL implement states arb_idle_st, arb_issue_st, arb_wait_st, arb_resp_st.
REQ-019 SHALL in arb_idle_st assert req_ready combinationally for the winner only; handshake = req_valid & req_ready.
REQ-020 SHALL arbitrate round-robin: one requester valid -> it wins; both valid -> the requester not granted last wins.
REQ-021 SHALL update the last-grant pointer only on a completed handshake.
REQ-022 SHALL on handshake latch op, a, b and owner, then go to arb_issue_st; invalid op (4'hA-4'hF) instead goes directly to arb_resp_st with error.
REQ-023 SHALL in arb_issue_st assert fpu_start for exactly one cycle, then go to arb_wait_st.
REQ-024 SHALL hold fpu_op/fpu_a/fpu_b stable from arb_issue_st until leaving arb_wait_st; zero otherwise.
REQ-025 SHALL in arb_wait_st count cycles from 1; on fpu_done latch fpu_result, err=0, go to arb_resp_st.
REQ-026 SHALL when the count reaches TIMEOUT_CYCLES without fpu_done go to arb_resp_st with result 0, err=1.
REQ-027 SHALL give fpu_done priority over timeout when both occur in the same cycle.
REQ-028 SHALL ignore fpu_done in any state other than arb_wait_st.
REQ-029 SHALL in arb_resp_st pulse rsp_valid[owner] for one cycle with rsp_result/rsp_err, then return to arb_idle_st.
REQ-030 SHALL produce minimum latency handshake->rsp_valid of 3 cycles (done in first wait cycle); invalid op: 1 cycle.
REQ-031 SHALL not accept a new request while busy; requesters hold valid and payload stable until ready.

Reset
REQ-032 SHALL on arst_n low immediately force arb_idle_st and drive all outputs 0 (req_ready 0, rsp_valid 0, fpu_start 0, busy 0, owner 0).
REQ-033 SHALL reset last-grant pointer to 1 so requester 0 wins the first contested grant.
REQ-034 SHALL drop any in-flight operation on reset without issuing a response.

Structure
REQ-035 SHALL place e_arb_state in shared package pa_fpu, reusing e_fpu_operation from it.
REQ-036 SHALL be a single module; no sub-modules.

Verification
REQ-037 SHALL cover: req0 mul a=0x3F800000 b=0x40000000, model done 2 cycles after start with 0x40000000 -> rsp_valid=2'b01, rsp_result=0x40000000, err=0.
REQ-038 SHALL cover: both valid after reset -> req0 granted first, req1 next, req0 third while both stay valid.
REQ-039 SHALL cover: req1 op=4'hC -> no fpu_start, rsp_valid=2'b10 next cycle, err=1, result 0.
REQ-040 SHALL cover: TIMEOUT_CYCLES=4, no fpu_done -> rsp err=1 after 4 wait cycles; fpu_done on cycle 4 -> err=0.
REQ-041 SHALL cover: arst_n low during arb_wait_st -> outputs 0 at once, no rsp_valid, next request served normally.
REQ-042 SHALL cover: spurious fpu_done in idle -> no response, state unchanged.
